// File: rtl/chip8_alu_sequencer_if.sv
// Bundles the start/done handshake, register-file port and ALU port of the
// CHIP-8 8XYN execute sequencer. slave = sequencer side, master = CPU/RF/ALU side.
interface chip8_alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ALU_W  = 16
);
  logic              start;
  logic [15:0]       opcode;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [3:0]        rf_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [ALU_W-1:0]  alu_in1;
  logic [ALU_W-1:0]  alu_in2;
  logic [3:0]        alu_sel;
  logic [ALU_W-1:0]  alu_out;
  logic              alu_carry;

  modport slave (
    input  start, opcode, rf_rdata, alu_out, alu_carry,
    output busy, done, illegal, rf_addr, rf_we, rf_wdata, alu_in1, alu_in2, alu_sel
  );

  modport master (
    output start, opcode, rf_rdata, alu_out, alu_carry,
    input  busy, done, illegal, rf_addr, rf_we, rf_wdata, alu_in1, alu_in2, alu_sel
  );
endinterface

// File: rtl/chip8_alu_sequencer.sv
// Multi-cycle execute stage for CHIP-8 8XYN ops: reads VX/VY, drives the ALU,
// writes the result to VX and then (for flagged ops) the flag to VF.
module chip8_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ALU_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  chip8_alu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RD_X, RD_Y, LAT_Y, EXEC, WB_X, WB_F, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;
  logic [3:0]        n_q, n_d;
  logic [DATA_W-1:0] vx_q, vx_d;
  logic [DATA_W-1:0] vy_q, vy_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              flag_q, flag_d;
  logic              illegal_q, illegal_d;

  logic              busy_c, done_c, illegal_c, rf_we_c;
  logic [3:0]        rf_addr_c, alu_sel_c;
  logic [DATA_W-1:0] rf_wdata_c;
  logic [ALU_W-1:0]  alu_in1_c, alu_in2_c;
  logic [ALU_W-1:0]  vx_ext, vy_ext;
  logic              flagged;
  logic              unused_alu_hi;

  function automatic logic op_supported(input logic [15:0] op);
    return (op[15:12] == 4'h8) && ((op[3] == 1'b0) || (op[3:0] == 4'hE));
  endfunction

  assign vx_ext  = {{(ALU_W-DATA_W){1'b0}}, vx_q};
  assign vy_ext  = {{(ALU_W-DATA_W){1'b0}}, vy_q};
  // Among supported N values, ADD/SUB/SHR/SUBN (4..7) and SHL (E) update VF.
  assign flagged = n_q[2] || (n_q == 4'hE);
  // Only the low byte of the ALU result is ever written back.
  assign unused_alu_hi = ^bus.alu_out[ALU_W-1:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      res_q     <= '0;
      flag_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      res_q     <= res_d;
      flag_q    <= flag_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs are decoded from the state register, so an asynchronous reset
  // forces them (rf_we included) back to zero without waiting for a clock.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    n_d        = n_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    res_d      = res_q;
    flag_d     = flag_q;
    illegal_d  = illegal_q;
    busy_c     = (state_q != IDLE);
    done_c     = 1'b0;
    illegal_c  = 1'b0;
    rf_addr_c  = 4'h0;
    rf_we_c    = 1'b0;
    rf_wdata_c = '0;
    alu_in1_c  = '0;
    alu_in2_c  = '0;
    alu_sel_c  = 4'h0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d       = bus.opcode[11:8];
          y_d       = bus.opcode[7:4];
          n_d       = bus.opcode[3:0];
          illegal_d = !op_supported(bus.opcode);
          state_d   = op_supported(bus.opcode) ? RD_X : FIN;
        end
      end
      RD_X: begin
        rf_addr_c = x_q;
        state_d   = RD_Y;
      end
      RD_Y: begin
        rf_addr_c = y_q;
        vx_d      = bus.rf_rdata;
        state_d   = LAT_Y;
      end
      LAT_Y: begin
        vy_d    = bus.rf_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        alu_in1_c = vx_ext;
        alu_in2_c = vy_ext;
        res_d     = bus.alu_out[DATA_W-1:0];
        flag_d    = 1'b0;
        case (n_q)
          4'h1: alu_sel_c = 4'd1;
          4'h2: alu_sel_c = 4'd2;
          4'h3: alu_sel_c = 4'd3;
          4'h4: begin
            alu_sel_c = 4'd4;
            flag_d    = bus.alu_carry;
          end
          4'h5: begin
            alu_sel_c = 4'd5;
            flag_d    = (vx_q >= vy_q);
          end
          4'h7: begin
            alu_sel_c = 4'd5;
            alu_in1_c = vy_ext;
            alu_in2_c = vx_ext;
            flag_d    = (vy_q >= vx_q);
          end
          4'h6: begin
            alu_sel_c = 4'd7;
            alu_in2_c = ALU_W'(1);
            flag_d    = vx_q[0];
          end
          4'hE: begin
            alu_sel_c = 4'd6;
            alu_in2_c = ALU_W'(1);
            flag_d    = vx_q[DATA_W-1];
          end
          default: begin
            // LD bypasses the ALU entirely.
            alu_in1_c = '0;
            alu_in2_c = '0;
            res_d     = vy_q;
          end
        endcase
        state_d = WB_X;
      end
      WB_X: begin
        rf_addr_c  = x_q;
        rf_we_c    = 1'b1;
        rf_wdata_c = res_q;
        state_d    = flagged ? WB_F : FIN;
      end
      WB_F: begin
        // Issued after the VX write so the flag wins when X is F.
        rf_addr_c  = 4'hF;
        rf_we_c    = 1'b1;
        rf_wdata_c = {{(DATA_W-1){1'b0}}, flag_q};
        state_d    = FIN;
      end
      FIN: begin
        done_c    = 1'b1;
        illegal_c = illegal_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.illegal  = illegal_c;
  assign bus.rf_addr  = rf_addr_c;
  assign bus.rf_we    = rf_we_c;
  assign bus.rf_wdata = rf_wdata_c;
  assign bus.alu_in1  = alu_in1_c;
  assign bus.alu_in2  = alu_in2_c;
  assign bus.alu_sel  = alu_sel_c;

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Bench for chip8_alu_sequencer: register file and ALU models, a directed vector
// table, reset/busy corner sequences and random ops against a reference model.
module tb_chip8_alu_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  chip8_alu_sequencer_if #(.DATA_W(8), .ALU_W(16)) bus ();

  chip8_alu_sequencer #(.DATA_W(8), .ALU_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // ALU: combinational, carry out of the 8-bit add
  logic [16:0] alu_sum;
  assign alu_sum = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
  always_comb begin
    bus.alu_out   = 16'h0000;
    bus.alu_carry = 1'b0;
    case (bus.alu_sel)
      4'd1: bus.alu_out = bus.alu_in1 | bus.alu_in2;
      4'd2: bus.alu_out = bus.alu_in1 & bus.alu_in2;
      4'd3: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      4'd4: begin
        bus.alu_out   = alu_sum[15:0];
        bus.alu_carry = (alu_sum > 17'd255);
      end
      4'd5: bus.alu_out = bus.alu_in1 - bus.alu_in2;
      4'd6: bus.alu_out = bus.alu_in1 << bus.alu_in2;
      4'd7: bus.alu_out = bus.alu_in1 >> bus.alu_in2;
      default: bus.alu_out = 16'h0000;
    endcase
  end

  // Register file: synchronous read, bench-side bulk preload
  logic [7:0] rf [16];
  logic [7:0] pre_vals [16];
  logic       pre_load = 1'b0;
  int         wr_count = 0;
  always @(posedge clk) begin
    bus.rf_rdata <= rf[bus.rf_addr];
    if (pre_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= pre_vals[i];
    end else if (bus.rf_we) begin
      rf[bus.rf_addr] <= bus.rf_wdata;
      wr_count <= wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] model_rf [16];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic check_rf(input string name);
    logic [127:0] got, exp;
    for (int i = 0; i < 16; i++) begin
      got[i*8 +: 8] = rf[i];
      exp[i*8 +: 8] = model_rf[i];
    end
    check(name, got, exp);
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) pre_vals[i] = model_rf[i];
    pre_load = 1'b1;
    @(posedge clk); #1;
    pre_load = 1'b0;
  endtask

  // Architectural effect of one instruction on the register image.
  task automatic ref_exec(input logic [15:0] op, output int lat, output bit ill, output int nwr);
    int x, y, n, vx, vy, r, f;
    bit has_f;
    x = int'(op[11:8]); y = int'(op[7:4]); n = int'(op[3:0]);
    vx = int'(model_rf[x]); vy = int'(model_rf[y]);
    ill = (op[15:12] != 4'h8) || !(n <= 7 || n == 14);
    r = 0; f = 0; has_f = 1;
    if (ill) begin
      lat = 1; nwr = 0;
    end else begin
      case (n)
        0: begin r = vy; has_f = 0; end
        1: begin r = vx | vy; has_f = 0; end
        2: begin r = vx & vy; has_f = 0; end
        3: begin r = vx ^ vy; has_f = 0; end
        4: begin r = vx + vy; f = (r > 255) ? 1 : 0; end
        5: begin r = vx - vy; f = (vx >= vy) ? 1 : 0; end
        7: begin r = vy - vx; f = (vy >= vx) ? 1 : 0; end
        6: begin r = vx / 2; f = vx % 2; end
        default: begin r = vx * 2; f = vx / 128; end
      endcase
      model_rf[x] = 8'(r & 255);
      if (has_f) model_rf[15] = 8'(f);
      lat = has_f ? 7 : 6;
      nwr = has_f ? 2 : 1;
    end
  endtask

  // Issue one op from IDLE; lat counts cycles after the accept edge until done (0 = timeout).
  task automatic run_op(input logic [15:0] op, output int lat, output bit ill, output int nwr);
    int w0;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.opcode = op;
    w0 = wr_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.opcode = 16'($urandom);
    lat = 1;
    seen = bus.done;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = bus.done;
    end
    ill = bus.illegal;
    if (!seen) lat = 0;
    @(posedge clk); #1;
    nwr = wr_count - w0;
    $display("op=%04h lat=%0d illegal=%0b writes=%0d", op, lat, ill, nwr);
  endtask

  function automatic logic [127:0] out_vec();
    return 128'({bus.busy, bus.done, bus.illegal, bus.rf_we, bus.rf_addr, bus.rf_wdata,
                 bus.alu_in1, bus.alu_in2, bus.alu_sel});
  endfunction

  typedef struct {
    logic [15:0] op;
    logic [7:0]  xv, yv, fv;
    logic [7:0]  ex, ef;
    int          lat;
    bit          ill;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, elat, nwr, enwr, dn, w0, cyc;
    bit ill, eill;
    logic [15:0] op;

    vec[0] = '{16'h8124, 8'hF0, 8'h20, 8'h00, 8'h10, 8'h01, 7, 1'b0};
    vec[1] = '{16'h8345, 8'h05, 8'h07, 8'hAA, 8'hFE, 8'h00, 7, 1'b0};
    vec[2] = '{16'h8347, 8'h05, 8'h07, 8'hAA, 8'h02, 8'h01, 7, 1'b0};
    vec[3] = '{16'h850E, 8'h81, 8'h33, 8'h00, 8'h02, 8'h01, 7, 1'b0};
    vec[4] = '{16'h8506, 8'h02, 8'h33, 8'h00, 8'h01, 8'h00, 7, 1'b0};
    vec[5] = '{16'h8671, 8'h0F, 8'hF0, 8'h55, 8'hFF, 8'h55, 6, 1'b0};
    vec[6] = '{16'h8F14, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'h01, 7, 1'b0};
    vec[7] = '{16'h8128, 8'h11, 8'h22, 8'h33, 8'h11, 8'h33, 1, 1'b1};
    vec[8] = '{16'h8120, 8'h11, 8'h22, 8'h77, 8'h22, 8'h77, 6, 1'b0};
    vec[9] = '{16'h9120, 8'h11, 8'h22, 8'h44, 8'h11, 8'h44, 1, 1'b1};

    bus.start = 1'b0;
    bus.opcode = 16'h0000;
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) model_rf[i] = 8'(i * 17);
    load_all();
    @(posedge clk); #1;
    check("reset_outputs", out_vec(), 128'h0);
    reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      model_rf[vec[i].op[11:8]] = vec[i].xv;
      model_rf[vec[i].op[7:4]]  = vec[i].yv;
      model_rf[15]              = vec[i].fv;
      load_all();
      ref_exec(vec[i].op, elat, eill, enwr);
      run_op(vec[i].op, lat, ill, nwr);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vec[i].lat));
      check($sformatf("vec%0d_illegal", i), 128'(ill), 128'(vec[i].ill));
      check($sformatf("vec%0d_vx", i), 128'(rf[vec[i].op[11:8]]), 128'(vec[i].ex));
      check($sformatf("vec%0d_vf", i), 128'(rf[15]), 128'(vec[i].ef));
      check($sformatf("vec%0d_writes", i), 128'(nwr), 128'(enwr));
      check_rf($sformatf("vec%0d_rf", i));
    end

    // Reset asserted during WB_X of an ADD: async output clear, no further writes
    model_rf[1] = 8'hF0; model_rf[2] = 8'h20; model_rf[15] = 8'h5A;
    load_all();
    bus.start = 1'b1; bus.opcode = 16'h8124;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.rf_we && bus.rf_addr == 4'h1) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reach_wbx", 128'(cyc < 20), 128'(1));
    w0 = wr_count;
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs", out_vec(), 128'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_writes", 128'(wr_count - w0), 128'(0));
    check("rst_vf_untouched", 128'(rf[15]), 128'(8'h5A));
    $display("reset mid-op vf=%02h writes_during_reset=%0d", rf[15], wr_count - w0);
    reset_n = 1'b1;
    load_all();
    ref_exec(16'h8124, elat, eill, enwr);
    run_op(16'h8124, lat, ill, nwr);
    check("post_rst_latency", 128'(lat), 128'(7));
    check("post_rst_rf", {120'h0, rf[1]}, 128'(8'h10));
    check_rf("post_rst_image");

    // start held high while busy must be ignored
    model_rf[6] = 8'h0F; model_rf[7] = 8'hF0; model_rf[15] = 8'h55;
    load_all();
    ref_exec(16'h8671, elat, eill, enwr);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = 16'h8671;
    @(posedge clk); #1;
    bus.opcode = 16'h8124;
    check("busy_after_accept", 128'(bus.busy), 128'(1));
    dn = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) bus.start = 1'b0;
      if (bus.done) dn++;
      @(posedge clk); #1;
    end
    $display("busy-start test dones=%0d busy=%0b", dn, bus.busy);
    check("busy_single_done", 128'(dn), 128'(1));
    check("busy_idle_after", 128'(bus.busy), 128'(0));
    check_rf("busy_rf");

    // Random ops against the reference model
    for (int i = 0; i < 16; i++) model_rf[i] = 8'($urandom);
    load_all();
    for (int t = 0; t < 40; t++) begin
      op = 16'($urandom);
      if ($urandom_range(0, 7) != 0) op[15:12] = 4'h8;
      ref_exec(op, elat, eill, enwr);
      run_op(op, lat, ill, nwr);
      check($sformatf("rnd%0d_latency", t), 128'(lat), 128'(elat));
      check($sformatf("rnd%0d_illegal", t), 128'(ill), 128'(eill));
      check($sformatf("rnd%0d_writes", t), 128'(nwr), 128'(enwr));
      check_rf($sformatf("rnd%0d_rf", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_alu_sequencer.md
Name: chip8_alu_sequencer

Overview:
- Multi-cycle execute stage for CHIP-8 8XYN register-register instructions.
- Sits directly upstream of the CPU ALU: reads VX and VY from the V register file, drives the ALU select and operands, and captures the ALU result and carry.
- Writes the result back to VX, then writes the flag to VF.
- Started by the CPU control FSM with a single-cycle start/done handshake.

Parameters:
- DATA_W, 8, V register width; ALU operands are zero-extended to 16 bits.
- ALU_W, 16, ALU operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- opcode  in  16  instruction word; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the instruction retires.
- illegal  out  1  valid with done; high if the opcode is not a supported 8XYN.
- rf_addr  out  4  register file read/write address.
- rf_rdata  in  8  register file read data; synchronous read, valid the cycle after rf_addr.
- rf_we  out  1  register file write enable.
- rf_wdata  out  8  register file write data.
- alu_in1  out  16  ALU operand 1.
- alu_in2  out  16  ALU operand 2.
- alu_sel  out  4  ALU operation select.
- alu_out  in  16  ALU result, combinational from alu_in1, alu_in2 and alu_sel.
- alu_carry  in  1  ALU carry, meaningful for ADD only.

Behaviour:
- Reset values: busy=0, done=0, illegal=0, rf_we=0, rf_addr=0, rf_wdata=0, alu_in1=0, alu_in2=0, alu_sel=0. All internal latches are 0 and the FSM is in IDLE.
- Reset asserted mid-operation: return to IDLE immediately. rf_we drops asynchronously. No further writes occur. Writes already committed are not undone.
- FSM states: IDLE, RD_X, RD_Y, LAT_Y, EXEC, WB_X, WB_F, FIN.
- IDLE:
  - On start, latch opcode.
  - Supported opcode: go to RD_X.
  - Unsupported opcode: go to FIN with illegal set.
- Supported opcodes: opcode[15:12]=8 and N in {0,1,2,3,4,5,6,7,E}.
- RD_X: rf_addr=X. → RD_Y.
- RD_Y: rf_addr=Y; latch vx=rf_rdata. → LAT_Y.
- LAT_Y: latch vy=rf_rdata. → EXEC.
- EXEC: drive the ALU per the table below; latch res=alu_out[7:0] and the flag. → WB_X.
- Operation table (operands zero-extended to 16 bits):
  - N=0 LD: res=vy, ALU unused (alu_sel=0), no flag.
  - N=1 OR: sel=1, in1=vx, in2=vy, no flag.
  - N=2 AND: sel=2, in1=vx, in2=vy, no flag.
  - N=3 XOR: sel=3, in1=vx, in2=vy, no flag.
  - N=4 ADD: sel=4, in1=vx, in2=vy, flag=alu_carry.
  - N=5 SUB: sel=5, in1=vx, in2=vy, flag=(vx>=vy).
  - N=7 SUBN: sel=5, in1=vy, in2=vx, flag=(vy>=vx).
  - N=6 SHR: sel=7, in1=vx, in2=1, flag=vx[0].
  - N=E SHL: sel=6, in1=vx, in2=1, flag=vx[7].
- Result width: res is always alu_out[7:0]; upper bits are discarded (SHL 0x80 gives 0x00, SUB wraps mod 256). SUB/SUBN/SHR/SHL flags are computed locally and do not use alu_carry.
- WB_X: rf_addr=X, rf_we=1, rf_wdata=res.
  - Flagged ops → WB_F.
  - LD/OR/AND/XOR → FIN (VF untouched).
- WB_F: rf_addr=F, rf_we=1, rf_wdata={7'b0,flag}. → FIN.
- X=F: the VF write follows the VX write, so the flag value wins.
- FIN: done=1 for one cycle; illegal is valid the same cycle. → IDLE.
- Latency from the start-accept edge to done: 7 cycles with flag, 6 without, 1 for illegal.
- start is ignored while busy. A new start can be accepted in the cycle after done.
- rf_we is high only in WB_X and WB_F, and never in the same cycle as a read address.

Test Plan:
- Reset mid-operation: assert reset_n=0 during WB_X of any op → outputs return to reset values asynchronously; no WB_F write; next start runs normally.
- ADD overflow: V1=0xF0, V2=0x20, opcode 0x8124 → V1=0x10, VF=1, done 7 cycles after accept, illegal=0.
- SUB with borrow: V3=0x05, V4=0x07, 0x8345 → V3=0xFE, VF=0. SUBN: V3=0x05, V4=0x07, 0x8347 → V3=0x02, VF=1.
- Shifts: V5=0x81, 0x850E → V5=0x02, VF=1. Then 0x8506 on V5=0x02 → V5=0x01, VF=0.
- Logic op: VF=0x55, V6=0x0F, V7=0xF0, opcode 0x8671 → V6=0xFF, VF stays 0x55, done 6 cycles after accept.
- Boundaries:
  - X=F: VF=0xFF, V1=0x01, 0x8F14 → final VF=0x01 (the flag write wins).
  - Illegal: opcode 0x8128 → done+illegal 1 cycle after accept, no rf_we.
  - start pulsed while busy → ignored; only one done.
